// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encoding and widths for the iterative multiplier
package mult_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int MULT_W = 32;
  localparam int CNT_W = $clog2(MULT_W);
endpackage

// File: rtl/mult_seq.sv
// mult_seq: iterative radix-2 signed multiplier with level request / one-cycle completion strobe
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mult_begin,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end
);
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_mag1, r_mag2, w_mag1, w_mag2;
  logic r_neg;
  logic [2*WIDTH-1:0] r_acc, r_product, w_addend, w_sum;
  logic w_last;
  assign w_mag1 = mult_op1[WIDTH-1] ? -mult_op1 : mult_op1;
  assign w_mag2 = mult_op2[WIDTH-1] ? -mult_op2 : mult_op2;
  assign w_addend = r_mag2[r_cnt] ? ({{WIDTH{1'b0}}, r_mag1} << r_cnt) : '0;
  assign w_sum = r_acc + w_addend;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign mult_end = r_state == DONE;
  assign product = r_product;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a dropped request aborts a busy multiply, DONE always returns to IDLE
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = mult_begin ? BUSY : IDLE;
      BUSY:    w_next = !mult_begin ? IDLE : (w_last ? DONE : BUSY);
      default: w_next = IDLE;
    endcase
  end
  // datapath: sample magnitudes on start, one shift-add per busy cycle, signed result on the last step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt     <= '0;
      r_mag1    <= '0;
      r_mag2    <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (r_state == IDLE && mult_begin) begin
      r_mag1 <= w_mag1;
      r_mag2 <= w_mag2;
      r_neg  <= mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == BUSY && mult_begin) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_product <= r_neg ? -w_sum : w_sum;
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed self-checking bench for mult_seq
module tb_mult_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] product;
  logic        mult_end;
  int errors = 0;
  int checks = 0;

  mult_seq dut (
    .clk(clk), .rst(rst), .mult_begin(mult_begin),
    .mult_op1(mult_op1), .mult_op2(mult_op2),
    .product(product), .mult_end(mult_end)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (mult_end) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    int n;
    mult_op1 = a;
    mult_op2 = b;
    mult_begin = 1'b1;
    wait_end(n);
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 33", name, n);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s product: got %h, expected %h", name, product, exp);
    end
    mult_begin = 1'b0;
    step();
    checks++;
    if (mult_end !== 1'b0) begin
      errors++;
      $display("FAIL %s strobe width: mult_end=%b after DONE, expected 0", name, mult_end);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mult_begin = 1'b0;
    mult_op1 = '0;
    mult_op2 = '0;
    repeat (2) step();
    checks++;
    if (product !== 64'h0) begin
      errors++;
      $display("FAIL reset product: got %h, expected 0", product);
    end
    checks++;
    if (mult_end !== 1'b0) begin
      errors++;
      $display("FAIL reset mult_end: got %b, expected 0", mult_end);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    run_mult("3x4", 32'd3, 32'd4, 64'h0000_0000_0000_000C);
    run_mult("max_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
  endtask

  task automatic test_signs();
    run_mult("-7x5", 32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFDD);
    run_mult("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
  endtask

  task automatic test_extremes();
    run_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mult("zero", 32'd0, 32'hFFFF_FFFF, 64'h0);
  endtask

  task automatic test_operand_hold();
    int n;
    mult_op1 = 32'd11;
    mult_op2 = 32'd13;
    mult_begin = 1'b1;
    repeat (3) step();
    mult_op1 = 32'd0;
    mult_op2 = 32'd0;
    wait_end(n);
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL hold latency: got %0d remaining cycles, expected 30", n);
    end
    checks++;
    if (product !== 64'd143) begin
      errors++;
      $display("FAIL hold product: got %h, expected %h", product, 64'd143);
    end
    mult_begin = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    mult_op1 = 32'd2;
    mult_op2 = 32'd5;
    mult_begin = 1'b1;
    wait_end(n);
    checks++;
    if (n !== 33 || product !== 64'd10) begin
      errors++;
      $display("FAIL b2b first: got %0d cycles product %h, expected 33 cycles product %h", n, product, 64'd10);
    end
    mult_op1 = 32'd6;
    mult_op2 = 32'd7;
    wait_end(n);
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL b2b spacing: got %0d cycles, expected 34", n);
    end
    checks++;
    if (product !== 64'd42) begin
      errors++;
      $display("FAIL b2b product: got %h, expected %h", product, 64'd42);
    end
    mult_begin = 1'b0;
    step();
    checks++;
    if (mult_end !== 1'b0) begin
      errors++;
      $display("FAIL b2b duplicate strobe: mult_end=%b, expected 0", mult_end);
    end
  endtask

  task automatic test_abort();
    int strobes;
    mult_op1 = 32'd9;
    mult_op2 = 32'd9;
    mult_begin = 1'b1;
    repeat (10) step();
    mult_begin = 1'b0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mult_end) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL abort strobe: got %0d strobes, expected 0", strobes);
    end
    checks++;
    if (product !== 64'd42) begin
      errors++;
      $display("FAIL abort product: got %h, expected %h", product, 64'd42);
    end
    run_mult("after_abort", 32'd9, 32'd9, 64'd81);
  endtask

  task automatic test_reset_busy();
    int n;
    mult_op1 = 32'd100;
    mult_op2 = 32'hFFFF_FFFD;
    mult_begin = 1'b1;
    repeat (15) step();
    rst = 1'b1;
    #1;
    checks++;
    if (product !== 64'h0 || mult_end !== 1'b0) begin
      errors++;
      $display("FAIL busy reset outputs: product %h mult_end %b, expected 0 and 0", product, mult_end);
    end
    step();
    rst = 1'b0;
    wait_end(n);
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL post-reset latency: got %0d cycles, expected 33", n);
    end
    checks++;
    if (product !== 64'hFFFF_FFFF_FFFF_FED4) begin
      errors++;
      $display("FAIL post-reset product: got %h, expected %h", product, 64'hFFFF_FFFF_FFFF_FED4);
    end
    mult_begin = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_operand_hold();
    test_back_to_back();
    test_abort();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
